// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared types for the pipeline hazard controller.
//   - state_t : sequencer state (RUN, DRAIN, HALTED)
//   - ctrl_t  : bundle of the per-cycle pipeline control outputs
//   - CTRL_*  : the only control combinations the sequencer ever produces
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic not_cache_stall;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic is_halted;
    } ctrl_t;

    // Normal forward progress; also what the pipeline sees while in reset.
    localparam ctrl_t CTRL_IDLE = '{
        pc_write: 1'b1, not_cache_stall: 1'b1, ifid_write: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, is_halted: 1'b0};

    // Core stopped for good; only reset leaves this.
    localparam ctrl_t CTRL_HALTED = '{
        pc_write: 1'b0, not_cache_stall: 1'b0, ifid_write: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, is_halted: 1'b1};

    // Cache miss: every pipeline register and the PC hold their value.
    localparam ctrl_t CTRL_FROZEN = '{
        pc_write: 1'b0, not_cache_stall: 1'b0, ifid_write: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b0, is_halted: 1'b0};

    // Wrong-path redirect: load the corrected PC and squash IF and ID.
    localparam ctrl_t CTRL_REDIRECT = '{
        pc_write: 1'b1, not_cache_stall: 1'b1, ifid_write: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b1, is_halted: 1'b0};

    // Ecall drain: let the ecall move down the pipe, stop fetching,
    // and feed bubbles into IF/ID behind it.
    localparam ctrl_t CTRL_DRAIN = '{
        pc_write: 1'b0, not_cache_stall: 1'b1, ifid_write: 1'b1,
        ifid_flush: 1'b1, idex_flush: 1'b0, is_halted: 1'b0};

    // Load-use: hold PC and IF/ID, insert one bubble into ID/EX.
    localparam ctrl_t CTRL_LOAD_USE = '{
        pc_write: 1'b0, not_cache_stall: 1'b1, ifid_write: 1'b0,
        ifid_flush: 1'b0, idex_flush: 1'b1, is_halted: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk     : clock
//     reset   : synchronous, active-high; clears the count and wins over inc
//     i_inc   : count this cycle
//     o_count : current count (registered)
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;

    // Holding at all-ones keeps long stalls from looking like short ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage pipeline. One prioritized
//   decision per cycle from cache busy, load-use, EX mispredict and ecall
//   halt draining, plus saturating stall/flush performance counters.
//   Ports:
//     clk, reset              : clock, synchronous active-high reset
//     i_icache_busy           : I-cache miss in progress (freeze)
//     i_dcache_busy           : D-cache miss in progress (freeze)
//     i_load_use_hazard       : ID instruction depends on load in EX
//     i_mispredict            : EX resolved a wrong next-PC this cycle
//     i_halt_req              : ID holds a halting ecall
//     i_wb_halt               : halting ecall retires in WB this cycle
//     o_pc_write              : PC update enable
//     o_not_cache_stall       : global enable for pipeline registers and PC
//     o_ifid_write            : IF/ID write enable
//     o_ifid_flush            : IF/ID -> bubble
//     o_idex_flush            : ID/EX -> bubble
//     o_is_halted             : core halted
//     o_stall_cnt             : cycles with PC held while not halted
//     o_flush_cnt             : mispredict redirects taken
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_icache_busy,
    input  logic             i_dcache_busy,
    input  logic             i_load_use_hazard,
    input  logic             i_mispredict,
    input  logic             i_halt_req,
    input  logic             i_wb_halt,
    output logic             o_pc_write,
    output logic             o_not_cache_stall,
    output logic             o_ifid_write,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_is_halted,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    state_t r_state;
    state_t w_next_state;
    ctrl_t  w_ctrl;
    logic   w_freeze;
    logic   w_flush_inc;
    logic   w_stall_inc;

    assign w_freeze = i_icache_busy | i_dcache_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Priority: HALTED > freeze > mispredict > drain/halt_req > load-use.
    // A freeze simply holds state; a mispredict hidden by the freeze is
    // re-presented by the frozen EX register afterwards, so nothing is
    // remembered here. While reset is asserted the pipeline sees the
    // normal run values so the rest of the core can clock cleanly.
    always_comb begin
        w_ctrl       = CTRL_IDLE;
        w_next_state = r_state;
        w_flush_inc  = 1'b0;
        if (!reset) begin
            if (r_state == ST_HALTED) begin
                w_ctrl = CTRL_HALTED;
            end else if (w_freeze) begin
                w_ctrl = CTRL_FROZEN;
            end else if (i_mispredict) begin
                // In DRAIN this means the halting ecall was wrong-path.
                w_ctrl       = CTRL_REDIRECT;
                w_flush_inc  = 1'b1;
                w_next_state = ST_RUN;
            end else if (r_state == ST_DRAIN) begin
                // Load-use is irrelevant here: everything behind the ecall
                // is already being flushed.
                w_ctrl = CTRL_DRAIN;
                if (i_wb_halt) begin
                    w_next_state = ST_HALTED;
                end
            end else if (i_halt_req) begin
                w_ctrl       = CTRL_DRAIN;
                w_next_state = ST_DRAIN;
            end else if (i_load_use_hazard) begin
                w_ctrl = CTRL_LOAD_USE;
            end
        end
    end

    assign w_stall_inc = !reset && !w_ctrl.pc_write && (r_state != ST_HALTED);

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_stall_inc),
        .o_count (o_stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset   (reset),
        .i_inc   (w_flush_inc),
        .o_count (o_flush_cnt)
    );

    assign o_pc_write        = w_ctrl.pc_write;
    assign o_not_cache_stall = w_ctrl.not_cache_stall;
    assign o_ifid_write      = w_ctrl.ifid_write;
    assign o_ifid_flush      = w_ctrl.ifid_flush;
    assign o_idex_flush      = w_ctrl.idex_flush;
    assign o_is_halted       = w_ctrl.is_halted;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Scoreboard bench: the driver pushes the expected outputs for each cycle
//   from a behavioural model; a monitor pops and compares on the falling
//   edge. Counters are narrowed to 4 bits so saturation is reachable.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          icacheBusy = 1'b0;
    logic          dcacheBusy = 1'b0;
    logic          loadUse = 1'b0;
    logic          mispredict = 1'b0;
    logic          haltReq = 1'b0;
    logic          wbHalt = 1'b0;
    logic          pcWrite;
    logic          notCacheStall;
    logic          ifidWrite;
    logic          ifidFlush;
    logic          idexFlush;
    logic          isHalted;
    logic [CW-1:0] stallCnt;
    logic [CW-1:0] flushCnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_icache_busy     (icacheBusy),
        .i_dcache_busy     (dcacheBusy),
        .i_load_use_hazard (loadUse),
        .i_mispredict      (mispredict),
        .i_halt_req        (haltReq),
        .i_wb_halt         (wbHalt),
        .o_pc_write        (pcWrite),
        .o_not_cache_stall (notCacheStall),
        .o_ifid_write      (ifidWrite),
        .o_ifid_flush      (ifidFlush),
        .o_idex_flush      (idexFlush),
        .o_is_halted       (isHalted),
        .o_stall_cnt       (stallCnt),
        .o_flush_cnt       (flushCnt)
    );

    // Expected controls packed as {pc, ncs, ifidW, ifidF, idexF, halted}.
    typedef struct {
        logic [5:0] ctl;
        int         st;
        int         fl;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    // Model: mode 0 = running, 1 = draining toward halt, 2 = halted.
    int   mMode = 0;
    int   mStall = 0;
    int   mFlush = 0;

    task automatic applyStimulus(input bit r, input bit ib, input bit db,
                                 input bit lu, input bit mp, input bit hr,
                                 input bit wh);
        exp_t       e;
        logic [5:0] c;
        bit         frozen;
        bit         redirect;
        @(posedge clk);
        #1;
        reset      = r;
        icacheBusy = ib;
        dcacheBusy = db;
        loadUse    = lu;
        mispredict = mp;
        haltReq    = hr;
        wbHalt     = wh;
        frozen   = ib | db;
        redirect = 1'b0;
        if (r)                      c = 6'b111000;
        else if (mMode == 2)        c = 6'b000001;
        else if (frozen)            c = 6'b000000;
        else if (mp) begin          c = 6'b111110; redirect = 1'b1; end
        else if (mMode == 1 || hr)  c = 6'b011100;
        else if (lu)                c = 6'b010010;
        else                        c = 6'b111000;
        e.ctl = c;
        e.st  = mStall;
        e.fl  = mFlush;
        sbq.push_back(e);
        if (r) begin
            mMode  = 0;
            mStall = 0;
            mFlush = 0;
        end else begin
            if (mMode != 2 && !c[5] && mStall < SAT) mStall++;
            if (redirect && mFlush < SAT) mFlush++;
            if (mMode != 2 && !frozen) begin
                if (mp)                    mMode = 0;
                else if (mMode == 1 && wh) mMode = 2;
                else if (mMode == 0 && hr) mMode = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [5:0] act;
        act = {pcWrite, notCacheStall, ifidWrite, ifidFlush, idexFlush, isHalted};
        total++;
        if (act !== e.ctl) begin
            bad++;
            $display("[TB] FAIL controls at %0t: got %b want %b", $time, act, e.ctl);
        end
        total++;
        if (int'(stallCnt) != e.st || $isunknown(stallCnt)) begin
            bad++;
            $display("[TB] FAIL stall_cnt at %0t: got %0d want %0d", $time, stallCnt, e.st);
        end
        total++;
        if (int'(flushCnt) != e.fl || $isunknown(flushCnt)) begin
            bad++;
            $display("[TB] FAIL flush_cnt at %0t: got %0d want %0d", $time, flushCnt, e.fl);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput(e);
            end
        end
    end

    initial begin : driver
        // One reset edge before checking so counters are defined.
        @(posedge clk);

        // Reset, then idle.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(5);

        // Load-use pulse.
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // D-cache freeze hiding a mispredict, then the redirect.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Halt drain, halted hold, reset out of halt.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1);
        idle(10);
        applyStimulus(0, 1, 0, 1, 1, 1, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Wrong-path ecall cancelled by mispredict.
        applyStimulus(0, 0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 0, 0);
        idle(2);

        // Stall counter saturation.
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 0, 1, 0, 0, 0);
        idle(2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 199) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 7) == 0,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 3) == 0);
        end

        // Let the monitor drain the scoreboard (bounded).
        for (int i = 0; i < 5 && sbq.size() > 0; i++) @(posedge clk);
        @(posedge clk);
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard drain: got %0d left want 0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the PC write enable and the global not-cache-stall enable. It also drives the IF/ID write and flush controls and the ID/EX flush. It combines cache busy, load-use hazard, EX-stage mispredict redirect and ecall-halt draining into one prioritized decision per cycle, and keeps stall/flush performance counters.

Parameters:
CNT_W, 32, width of the saturating performance counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
icache_busy  in  1  I-cache miss in progress; pipeline must freeze
dcache_busy  in  1  D-cache miss in progress; pipeline must freeze
load_use_hazard  in  1  ID instruction depends on load in EX
mispredict  in  1  EX resolved a wrong next-PC; redirect this cycle
halt_req  in  1  ID holds ecall with halt condition
wb_halt  in  1  halting ecall retires in WB this cycle
pc_write  out  1  PC update enable
not_cache_stall  out  1  global enable for all pipeline registers and PC
ifid_write  out  1  IF/ID write enable
ifid_flush  out  1  IF/ID -> bubble
idex_flush  out  1  ID/EX -> bubble
is_halted  out  1  core halted
stall_cnt  out  CNT_W  cycles with pc_write=0 while not halted
flush_cnt  out  CNT_W  mispredict redirects taken

Behaviour:
- State register (sync reset to RUN): RUN, DRAIN, HALTED. All controls are combinational from state and inputs. Counters are registered.
- freeze = icache_busy | dcache_busy.
- Priority, highest first:
  - HALTED
  - freeze
  - mispredict
  - halt_req (in RUN)
  - load_use_hazard
  - none
- HALTED: pc_write=0, not_cache_stall=0, ifid_write=0, flushes=0, is_halted=1. No exit except reset.
- freeze (RUN or DRAIN): not_cache_stall=0, pc_write=0, ifid_write=0, flushes=0. No state change; wb_halt and mispredict are ignored that cycle.
  - The block never latches mispredict. The frozen EX register re-presents it after the freeze.
- mispredict (not frozen): pc_write=1, ifid_write=1, ifid_flush=1, idex_flush=1. flush_cnt increments.
  - Overrides load_use_hazard and halt_req in the same cycle.
  - In DRAIN, a mispredict means the halting ecall was on the wrong path: next state RUN.
- RUN with halt_req (no freeze, no mispredict): pc_write=0, ifid_write=1, ifid_flush=1, idex_flush=0. The ecall advances and fetch stops. Next state DRAIN.
- DRAIN (no freeze): pc_write=0, ifid_flush=1, idex_flush=0, ifid_write=1.
  - wb_halt -> HALTED next cycle.
  - load_use_hazard is ignored in DRAIN.
- RUN with load_use_hazard only: pc_write=0, ifid_write=0, idex_flush=1, ifid_flush=0.
- RUN with no events: pc_write=1, ifid_write=1, not_cache_stall=1, no flushes.
- not_cache_stall=1 in every non-frozen, non-halted cycle.
- Reset values: state RUN, counters 0, is_halted=0.
  - During reset cycles all outputs take their RUN/no-event values, using input-qualified gating.
  - Reset mid-DRAIN or in HALTED returns to RUN.
- stall_cnt increments each cycle with pc_write=0 and state != HALTED, including cycles when reset is deasserted but frozen.
- Both counters saturate at all-ones.
- When increment and reset coincide, reset wins.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN, DRAIN, HALTED) and state width constant.
- One sub-module is natural: sat_counter (param CNT_W, inputs clk, reset, inc; output count), instantiated twice.

Test Plan:
- Reset 2 cycles, then idle 5 cycles -> pc_write=1, not_cache_stall=1, ifid_write=1, no flushes, stall_cnt=0.
- load_use_hazard pulse 1 cycle -> that cycle pc_write=0, ifid_write=0, idex_flush=1; stall_cnt=1 afterwards.
- dcache_busy 4 cycles with mispredict=1 throughout, then mispredict held 1 more cycle with busy low:
  - busy cycles: not_cache_stall=0.
  - first free cycle: all flushes=1, pc_write=1.
  - flush_cnt=1, stall_cnt=4.
- halt_req, then wb_halt 3 cycles later:
  - DRAIN cycles pc_write=0, ifid_flush=1.
  - is_halted=1 from the cycle after wb_halt.
  - outputs stay frozen for 10 idle cycles.
  - reset -> is_halted=0, pc_write=1.
- halt_req, next cycle mispredict -> state RUN, flush_cnt=1, pc_write=1 on the following idle cycle, is_halted stays 0.
- CNT_W=4, load_use_hazard held 20 cycles -> stall_cnt saturates at 15, no wrap.
